mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single memory_unit command port among NUM_REQ requesters, such as the traversal engine, the execute engine and the allocator/GC.
- Per grant, it latches the winner's command, drives the memory_unit with a one-cycle execute pulse, and waits for is_ready.
- It then returns addr_out/data_out to the winner with a one-cycle done pulse.
- A watchdog aborts hung transactions, and illegal func codes are rejected without touching memory.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 10, memory address width (matches memory_unit)
DATA_W, 66, memory data width (matches memory_unit)
TIMEOUT, 255, max cycles in WAIT before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request i pending; held with its command until done[i]
req_func  in  2*NUM_REQ  func of requester i at bits [2i+1:2i]
req_addr  in  ADDR_W*NUM_REQ  addr_in of requester i, flattened
req_data  in  DATA_W*NUM_REQ  data_in of requester i, flattened
done  out  NUM_REQ  one-cycle completion pulse to requester i
err  out  1  qualifies done: 1 means illegal func or timeout
rsp_addr  out  ADDR_W  registered addr_out of last transaction (broadcast)
rsp_data  out  DATA_W  registered data_out of last transaction (broadcast)
busy  out  1  high in any state except IDLE
grant_id  out  3  index of current or last granted requester
timeout_flag  out  1  sticky; set on any timeout; cleared only by rst
mem_func  out  2  to memory_unit func
mem_execute  out  1  to memory_unit execute
mem_addr_in  out  ADDR_W  to memory_unit addr_in
mem_data_in  out  DATA_W  to memory_unit data_in
mem_is_ready  in  1  from memory_unit is_ready
mem_addr_out  in  ADDR_W  from memory_unit addr_out
mem_data_out  in  DATA_W  from memory_unit data_out

Behaviour:
- Reset: when rst=1 on a clk edge, all outputs go to 0, the state goes to IDLE, the RR pointer goes to NUM_REQ-1 and the watchdog counter goes to 0. This applies mid-transaction too: there is no done pulse for the aborted request.
- Registered outputs: all outputs are registered.
- IDLE:
  - If any req_valid=1 and mem_is_ready=1, pick the first valid index searching from pointer+1 upward with wrap-around.
  - Set grant_id and pointer to that index, and latch its func/addr/data into the mem_* registers.
  - If func=2'b11, go to DONE with err=1 and do not issue to memory. Otherwise go to ISSUE.
  - If mem_is_ready=0 (memory_unit still initialising or busy), stay in IDLE and grant nothing.
- ISSUE: mem_execute=1 for exactly this one cycle. Clear the watchdog counter and go to WAIT.
- WAIT:
  - mem_execute=0. The cycle after ISSUE is the earliest sample point, and GET_FREE completes there.
  - If mem_is_ready=1, capture mem_addr_out into rsp_addr and mem_data_out into rsp_data, then go to DONE with err=0.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with still no ready, go to DONE with err=1 and set timeout_flag; rsp_* are unchanged.
- DONE: done[grant_id]=1 for one cycle; err is valid in the same cycle. Go to IDLE. err and done return to 0 the next cycle.
- Latency, from req_valid sampled in IDLE to done:
  - GET_FREE: 4 cycles (IDLE→ISSUE→WAIT→DONE).
  - Reads/writes: 3 + memory latency cycles.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Requester contract:
  - Drop or change the command in the cycle after done.
  - A still-high valid in the following IDLE is a new request.
  - Commands must be stable while valid=1. The arbiter samples them only in IDLE.
- Fairness: a requester waits at most NUM_REQ-1 other transactions. Simultaneous requests are served in rotating order.
- Withdrawal: valid deasserted before grant is allowed. Deassertion after grant is ignored; the transaction completes.
- grant_id width is fixed at 3 bits; the upper bits are 0 for small NUM_REQ.

Test Plan:
- Single read: after memory init, req 0 GET_CONTENTS addr 0x005 (mem[5]=0x1234) → one mem_execute pulse with mem_func=GET_CONTENTS and mem_addr_in=0x005; done[0] with err=0 and rsp_data=0x1234.
- Round-robin: req 0, 1 and 2 all valid in the same cycle and held → grants in order 0,1,2. Then req 2 and 0 re-raised → order 0 then 2 (pointer at 2).
- GET_FREE: two back-to-back GET_FREE from req 1 with free start 0x020 → rsp_addr 0x020 then 0x021; each done 4 cycles after its valid was sampled.
- Illegal func: req 1 func=2'b11 → mem_execute stays 0; done[1] with err=1 two cycles after sampling; memory contents unchanged.
- Timeout: stub holding mem_is_ready=0 after issue, TIMEOUT=8 → done with err=1 and timeout_flag=1; mem_execute pulsed exactly once; rsp_* unchanged.
- Reset mid-WAIT: rst=1 for one cycle during WAIT → next cycle busy=0, done=0, mem_execute=0. The following requests are granted starting from requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory_unit command port among
// NUM_REQ requesters. Each grant latches the winner's command, pulses execute
// once, waits for is_ready (bounded by a watchdog) and answers the winner with
// a one-cycle done pulse qualified by err.
module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 66,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_func,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [ADDR_W-1:0]         rsp_addr,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      timeout_flag,
  output logic [1:0]                mem_func,
  output logic                      mem_execute,
  output logic [ADDR_W-1:0]         mem_addr_in,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic                      mem_is_ready,
  input  logic [ADDR_W-1:0]         mem_addr_out,
  input  logic [DATA_W-1:0]         mem_data_out
);

  localparam logic [1:0]  FUNC_ILLEGAL = 2'b11;
  localparam logic [15:0] WDOG_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          grant_q, grant_d;
  logic [1:0]          func_q, func_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                exec_q, exec_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                tflag_q, tflag_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          pick;

  // First valid requester strictly after the pointer, wrapping around.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                         input logic [2:0] p);
    logic [2:0]         sel;
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    sel   = p;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(p) + k) % NUM_REQ;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        sel   = 3'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next-state and next-output computation for the grant/issue/wait/done sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    func_d  = func_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    exec_d  = 1'b0;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = 1'b0;
    tflag_d = tflag_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(req_valid, ptr_q);
    unique case (state_q)
      S_IDLE: begin
        // Nothing is granted while the memory is initialising or busy.
        if ((|req_valid) && mem_is_ready) begin
          ptr_d   = pick;
          grant_d = pick;
          func_d  = 2'(req_func >> (2 * int'(pick)));
          maddr_d = ADDR_W'(req_addr >> (ADDR_W * int'(pick)));
          mdata_d = DATA_W'(req_data >> (DATA_W * int'(pick)));
          if (func_d == FUNC_ILLEGAL) begin
            // Rejected without ever touching memory.
            state_d = S_DONE;
            done_d  = NUM_REQ'(1) << pick;
            err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            exec_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (mem_is_ready) begin
          raddr_d = mem_addr_out;
          rdata_d = mem_data_out;
          state_d = S_DONE;
          done_d  = NUM_REQ'(1) << grant_q;
        end else if (cnt_q == WDOG_LAST) begin
          // Watchdog abort: response registers keep the previous result.
          state_d = S_DONE;
          done_d  = NUM_REQ'(1) << grant_q;
          err_d   = 1'b1;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything and points RR at the last requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'(NUM_REQ - 1);
      grant_q <= '0;
      func_q  <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      exec_q  <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      tflag_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      func_q  <= func_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      exec_q  <= exec_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      tflag_q <= tflag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done         = done_q;
  assign err          = err_q;
  assign rsp_addr     = raddr_q;
  assign rsp_data     = rdata_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign timeout_flag = tflag_q;
  assign mem_func     = func_q;
  assign mem_execute  = exec_q;
  assign mem_addr_in  = maddr_q;
  assign mem_data_in  = mdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural memory_unit
// responder and a transaction-level reference model of arbitration order and
// memory contents.
module tb_mem_arbiter;
  localparam int N   = 3;
  localparam int AW  = 10;
  localparam int DW  = 66;
  localparam int TO  = 8;
  localparam int FW  = 2 * N;
  localparam int AFW = AW * N;
  localparam int DFW = DW * N;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [FW-1:0]  req_func;
  logic [AFW-1:0] req_addr;
  logic [DFW-1:0] req_data;
  logic [N-1:0]   done;
  logic           err;
  logic [AW-1:0]  rsp_addr;
  logic [DW-1:0]  rsp_data;
  logic           busy;
  logic [2:0]     grant_id;
  logic           timeout_flag;
  logic [1:0]     mem_func;
  logic           mem_execute;
  logic [AW-1:0]  mem_addr_in;
  logic [DW-1:0]  mem_data_in;
  logic           mem_is_ready;
  logic [AW-1:0]  mem_addr_out;
  logic [DW-1:0]  mem_data_out;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_func(req_func),
    .req_addr(req_addr), .req_data(req_data), .done(done), .err(err),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id),
    .timeout_flag(timeout_flag), .mem_func(mem_func), .mem_execute(mem_execute),
    .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_is_ready(mem_is_ready), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out)
  );

  typedef struct { int idx; logic err; logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
  typedef struct { logic [1:0] f; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;

  exp_t expq[$];
  cmd_t cmdq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exec_cnt = 0;
  int   exp_exec = 0;
  int   force_lat = 0;
  bit   hang = 1'b0;

  // reference model state
  logic [DW-1:0] mdl_mem [0:1023];
  logic [AW-1:0] mdl_free;
  logic [AW-1:0] mdl_raddr;
  logic [DW-1:0] mdl_rdata;
  int            mdl_ptr;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return DW'(66'h1234);
    return DW'(66'h2_0000_0000_0000_0000) | (DW'(i) << 20) | DW'(i * 7919);
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Transaction-level model: one served command -> expected response and memory command.
  task automatic model_txn(input int idx, input logic [1:0] f, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit hung);
    exp_t e;
    cmd_t c;
    mdl_ptr = idx;
    e.idx = idx;
    e.err = 1'b0;
    if (f == 2'b11) begin
      e.err = 1'b1;
    end else begin
      c.f = f; c.a = a; c.d = d;
      cmdq.push_back(c);
      exp_exec++;
      if (hung) e.err = 1'b1;
      else if (f == 2'b00) begin mdl_raddr = a; mdl_rdata = mdl_mem[a]; end
      else if (f == 2'b01) begin mdl_mem[a] = d; mdl_raddr = a; mdl_rdata = d; end
      else begin mdl_raddr = mdl_free; mdl_rdata = '0; mdl_free = mdl_free + 1'b1; end
    end
    e.a = mdl_raddr;
    e.d = mdl_rdata;
    expq.push_back(e);
  endtask

  task automatic set_cmd(input int i, input logic [1:0] f, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_func = (req_func & ~(FW'(3) << (2 * i))) | (FW'(f) << (2 * i));
    req_addr = (req_addr & ~(AFW'({AW{1'b1}}) << (AW * i))) | (AFW'(a) << (AW * i));
    req_data = (req_data & ~(DFW'({DW{1'b1}}) << (DW * i))) | (DFW'(d) << (DW * i));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (!busy && mem_is_ready) ok = 1'b1;
    end
    if (!ok) fail_now("wait_idle");
  endtask

  task automatic wait_done(input int idx, output int edges);
    bit ok = 1'b0;
    edges = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bit_of(done, idx)) ok = 1'b1;
    end
    if (!ok) fail_now("wait_done");
  endtask

  task automatic do_single(input int idx, input logic [1:0] f, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat, input bit hung,
                           input int exp_edges);
    int edges;
    wait_idle();
    force_lat = lat;
    hang = hung;
    set_cmd(idx, f, a, d);
    model_txn(idx, f, a, d, hung);
    req_valid = req_valid | (N'(1) << idx);
    wait_done(idx, edges);
    req_valid = req_valid & ~(N'(1) << idx);
    hang = 1'b0;
    force_lat = 0;
    check("latency", DW'(edges), DW'(exp_edges));
  endtask

  task automatic rand_cmd(output logic [1:0] f, output logic [AW-1:0] a, output logic [DW-1:0] d);
    int r = $urandom_range(0, 9);
    f = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    a = AW'($urandom_range(0, 31));
    d = DW'({$urandom, $urandom, $urandom});
  endtask

  // Raise every requester in mask at once; expected service order is the rotation after the last grant.
  task automatic run_batch(input logic [N-1:0] mask);
    logic [N-1:0]  rem = mask;
    logic [1:0]    f;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            p;
    int            sel;
    bit            ok = 1'b0;
    wait_idle();
    p = mdl_ptr;
    while (rem != '0) begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        if (sel < 0 && bit_of(rem, (p + k) % N)) sel = (p + k) % N;
      end
      rand_cmd(f, a, d);
      set_cmd(sel, f, a, d);
      model_txn(sel, f, a, d, 1'b0);
      rem = rem & ~(N'(1) << sel);
      p = sel;
    end
    req_valid = mask;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~done;
      if (req_valid == '0) ok = 1'b1;
    end
    if (!ok) fail_now("batch_complete");
  endtask

  // memory_unit responder: busy for a given latency after each execute, initialising at start.
  initial begin
    logic [DW-1:0] stub_mem [0:1023];
    logic [AW-1:0] stub_free = AW'(10'h020);
    logic [1:0]    s_f;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    int            cnt = 0;
    bit            hanging = 1'b0;
    bit            prev_exec = 1'b0;
    cmd_t          c;
    for (int i = 0; i < 1024; i++) stub_mem[AW'(i)] = init_val(i);
    mem_is_ready = 1'b0;
    mem_addr_out = '0;
    mem_data_out = '0;
    repeat (12) @(negedge clk);
    mem_is_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_execute) begin
        exec_cnt++;
        check("exec_single_pulse", DW'(prev_exec), DW'(0));
        if (cmdq.size() == 0) begin
          fail_now("unexpected_execute");
        end else begin
          c = cmdq.pop_front();
          check("mem_func", DW'(mem_func), DW'(c.f));
          check("mem_addr_in", DW'(mem_addr_in), DW'(c.a));
          if (c.f == 2'b01) check("mem_data_in", mem_data_in, c.d);
        end
        s_f = mem_func; s_a = mem_addr_in; s_d = mem_data_in;
        mem_is_ready = 1'b0;
        if (hang) hanging = 1'b1;
        else cnt = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
      end else if (hanging) begin
        if (|done) begin hanging = 1'b0; mem_is_ready = 1'b1; end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (s_f == 2'b00) begin mem_addr_out = s_a; mem_data_out = stub_mem[s_a]; end
          else if (s_f == 2'b01) begin stub_mem[s_a] = s_d; mem_addr_out = s_a; mem_data_out = s_d; end
          else begin mem_addr_out = stub_free; mem_data_out = '0; stub_free = stub_free + 1'b1; end
          mem_is_ready = 1'b1;
        end
      end
      prev_exec = mem_execute;
    end
  end

  // Scoreboard monitor: every done/err presented by the DUT consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((|done) || err) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=%b err=%b expected no completion", done, err);
        end else begin
          e = expq.pop_front();
          check("done_vec", DW'(done), DW'(N'(1) << e.idx));
          check("grant_id", DW'(grant_id), DW'(e.idx));
          check("err", DW'(err), DW'(e.err));
          check("rsp_addr", DW'(rsp_addr), DW'(e.a));
          check("rsp_data", rsp_data, e.d);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation bound reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int ex0;
    int edges;
    cmd_t c;
    logic [N-1:0] m;
    for (int i = 0; i < 1024; i++) mdl_mem[AW'(i)] = init_val(i);
    mdl_free = AW'(10'h020);
    mdl_raddr = '0;
    mdl_rdata = '0;
    mdl_ptr = N - 1;
    rst = 1'b1;
    req_valid = '0;
    req_func = '0;
    req_addr = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_done", DW'(done), DW'(0));
    check("rst_err", DW'(err), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_grant_id", DW'(grant_id), DW'(0));
    check("rst_execute", DW'(mem_execute), DW'(0));
    check("rst_mem_func", DW'(mem_func), DW'(0));
    check("rst_mem_addr_in", DW'(mem_addr_in), DW'(0));
    check("rst_mem_data_in", mem_data_in, DW'(0));
    check("rst_rsp_addr", DW'(rsp_addr), DW'(0));
    check("rst_rsp_data", rsp_data, DW'(0));
    check("rst_timeout_flag", DW'(timeout_flag), DW'(0));
    rst = 1'b0;

    // Request raised while the memory is still initialising: no grant until ready.
    set_cmd(0, 2'b00, AW'(5), '0);
    model_txn(0, 2'b00, AW'(5), '0, 1'b0);
    req_valid = N'(1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || mem_execute) bad++;
    end
    check("no_grant_while_not_ready", DW'(bad), DW'(0));
    wait_done(0, edges);
    req_valid = '0;
    check("single_read_data", rsp_data, DW'(66'h1234));

    // Read with 3-cycle memory latency.
    do_single(0, 2'b00, AW'(5), '0, 3, 1'b0, 5);
    check("read_lat3_data", rsp_data, DW'(66'h1234));

    // Back-to-back GET_FREE from requester 1.
    do_single(1, 2'b10, '0, '0, 1, 1'b0, 3);
    check("get_free_first", DW'(rsp_addr), DW'(10'h020));
    do_single(1, 2'b10, '0, '0, 1, 1'b0, 3);
    check("get_free_second", DW'(rsp_addr), DW'(10'h021));

    // Illegal func: no execute, memory untouched.
    ex0 = exec_cnt;
    do_single(1, 2'b11, AW'(5), DW'(66'h3_DEAD_BEEF), 0, 1'b0, 1);
    check("illegal_no_execute", DW'(exec_cnt - ex0), DW'(0));
    do_single(2, 2'b00, AW'(5), '0, 2, 1'b0, 4);
    check("illegal_mem_unchanged", rsp_data, DW'(66'h1234));

    // Watchdog timeout with a memory that never becomes ready.
    ex0 = exec_cnt;
    do_single(2, 2'b00, AW'(7), '0, 0, 1'b1, TO + 2);
    check("timeout_flag_set", DW'(timeout_flag), DW'(1));
    check("timeout_one_execute", DW'(exec_cnt - ex0), DW'(1));

    // Reset in the middle of WAIT: transaction vanishes without done.
    wait_idle();
    force_lat = 6;
    set_cmd(0, 2'b00, AW'(3), '0);
    c.f = 2'b00; c.a = AW'(3); c.d = '0;
    cmdq.push_back(c);
    exp_exec++;
    req_valid = N'(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    force_lat = 0;
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_done", DW'(done), DW'(0));
    check("midrst_execute", DW'(mem_execute), DW'(0));
    check("midrst_timeout_flag", DW'(timeout_flag), DW'(0));
    mdl_ptr = N - 1;
    mdl_raddr = '0;
    mdl_rdata = '0;

    // Round robin after reset: 0,1,2 then {0,2} gives 0 then 2.
    run_batch(3'b111);
    run_batch(3'b101);

    // Randomised batches of simultaneous requests.
    for (int t = 0; t < 60; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      run_batch(m);
    end

    repeat (10) @(negedge clk);
    check("expq_drained", DW'(expq.size()), DW'(0));
    check("cmdq_drained", DW'(cmdq.size()), DW'(0));
    check("execute_total", DW'(exec_cnt), DW'(exp_exec));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
